apb_master_ctrl: RTL
====================

Name: apb_master_ctrl

Overview:
- APB requester stage: accepts single read/write commands from the test/system side over a valid/ready handshake.
- Sequences each command through APB SETUP/ACCESS phases and returns one response per command (read data plus error flags).
- Sits directly upstream of the APB slave fabric. Its APB-side outputs are the signals the master-side bench interface observes.

Parameters:
- ADDR_WIDTH, 32, APB address width (bits).
- DATA_WIDTH, 32, APB data width (bits); must be 8, 16 or 32.
- ADDR_LIMIT, 32'h0000_FFFF, highest legal byte address; commands above it are rejected locally.

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when cmd_valid is also high
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_master_error  out  1  command rejected locally (misaligned or out of range); no APB transfer issued
- rsp_other_error  out  1  slave returned pslverr (or timeout, see Optional Feature)
- paddr  out  ADDR_WIDTH  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_WIDTH  APB write data
- pstrb  out  DATA_WIDTH/8  APB strobes; forced to 0 on reads
- pprot  out  3  APB protection
- pready  in  1  slave ready
- prdata  in  DATA_WIDTH  slave read data
- pslverr  in  1  slave error

Behaviour:
- Reset (async assert, sync release): state=IDLE.
  - cmd_ready=1; rsp_valid=0.
  - psel, penable, pwrite, paddr, pwdata, pstrb, pprot all 0; rsp_* all 0.
- FSM has four states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1. On cmd_valid, register all cmd_* fields.
  - Misaligned address (cmd_addr mod DATA_WIDTH/8 != 0) or cmd_addr > ADDR_LIMIT: go to RESP with master_error=1. psel never asserts.
  - Otherwise: go to SETUP.
- SETUP:
  - cmd_ready=0; psel=1, penable=0; address, control and data driven from registers.
  - Always advances to ACCESS after exactly 1 cycle.
- ACCESS:
  - psel=1, penable=1. All APB outputs are held stable until pready=1.
  - When pready=1: capture prdata if it is a read; other_error=pslverr; go to RESP.
  - On read with pslverr=1, rsp_rdata=0.
- RESP:
  - rsp_valid=1 for exactly one cycle; psel=0, penable=0; then go to IDLE.
  - No back-to-back APB transfers: a new command is accepted no earlier than the cycle after RESP.
- Latency: zero-wait-state slave gives cmd accept -> rsp_valid in 3 cycles (SETUP, ACCESS, RESP). Each wait state adds 1 cycle.
- Local-reject latency: accept -> rsp_valid in 1 cycle.
- paddr, pwrite, pwdata and pprot are not required to return to 0 between transfers; they hold their last values.
- Reset asserted mid-transfer: all outputs return to reset values immediately. The pending command is dropped and no response is issued.
- pready or pslverr seen outside ACCESS is ignored.
- pstrb=0 on reads regardless of cmd_strb.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYCLES (default 16) and a counter that clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES: abort the transfer (psel and penable drop) and go to RESP with other_error=1, rsp_rdata=0.
  - If pready=1 arrives in the same cycle the limit is reached, pready wins and the transfer completes normally.
- Not defined: ACCESS waits indefinitely for pready; no counter logic is present.

Test Plan:
- Write 0x0000_0010, data 0xA5A5_5A5A, strb 4'hF, pready tied 1 -> psel rises cycle+1, penable cycle+2, rsp_valid cycle+3 with both errors 0, pstrb=4'hF.
- Read 0x0000_0020, slave inserts 2 wait states, prdata=0x1234_5678 -> rsp_valid at cycle+5, rsp_rdata=0x1234_5678, APB outputs stable across waits.
- Read 0x0000_0003 (misaligned), then write 0x0001_0000 (above limit) -> each gives rsp_valid the cycle after accept with master_error=1; psel stays 0.
- Write with pslverr=1 at completion -> rsp_other_error=1, rsp_rdata=0; next command accepted the cycle after RESP.
- rstn driven low during ACCESS -> psel, penable and cmd_ready go to reset values asynchronously; no rsp_valid after release; next command runs normally.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready held 0 -> abort after 16 ACCESS cycles with rsp_other_error=1.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: APB requester stage.
// Accepts one read/write command at a time over a valid/ready handshake and
// sequences it through the APB SETUP and ACCESS phases. It returns exactly one
// response per command. Misaligned or out-of-range commands are answered
// locally, and no APB transfer is issued for them.
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES cycles without pready.
module apb_master_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 32'h0000_FFFF
`ifdef APB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 16
`endif
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb,
   input  logic [2:0]              cmd_prot,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_master_error,
   output logic                    rsp_other_error,
   output logic [ADDR_WIDTH-1:0]   paddr,
   output logic                    psel,
   output logic                    penable,
   output logic                    pwrite,
   output logic [DATA_WIDTH-1:0]   pwdata,
   output logic [DATA_WIDTH/8-1:0] pstrb,
   output logic [2:0]              pprot,
   input  logic                    pready,
   input  logic [DATA_WIDTH-1:0]   prdata,
   input  logic                    pslverr
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t state_r;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_WIDTH-1:0] wait_cnt_r;
`endif

   // A command is rejected locally if it is not aligned to the bus width or
   // if it lies above the legal address window.
   function automatic logic cmd_reject(input logic [ADDR_WIDTH-1:0] addr);
      logic misaligned;
      misaligned = (addr % ADDR_WIDTH'(STRB_WIDTH)) != {ADDR_WIDTH{1'b0}};
      return misaligned || (addr > ADDR_LIMIT);
   endfunction

   wire reject_s = cmd_reject(cmd_addr);

   // Control FSM. All handshake, APB and response outputs are registered here.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r          <= IDLE;
         cmd_ready        <= 1'b1;
         rsp_valid        <= 1'b0;
         rsp_rdata        <= {DATA_WIDTH{1'b0}};
         rsp_master_error <= 1'b0;
         rsp_other_error  <= 1'b0;
         paddr            <= {ADDR_WIDTH{1'b0}};
         psel             <= 1'b0;
         penable          <= 1'b0;
         pwrite           <= 1'b0;
         pwdata           <= {DATA_WIDTH{1'b0}};
         pstrb            <= {STRB_WIDTH{1'b0}};
         pprot            <= 3'b000;
`ifdef APB_TIMEOUT_EN
         wait_cnt_r       <= {CNT_WIDTH{1'b0}};
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  if (reject_s) begin
                     // Answer locally. The APB outputs keep their last values
                     // and psel stays low.
                     state_r          <= RESP;
                     rsp_valid        <= 1'b1;
                     rsp_master_error <= 1'b1;
                     rsp_other_error  <= 1'b0;
                     rsp_rdata        <= {DATA_WIDTH{1'b0}};
                  end else begin
                     // The APB output registers double as the command register.
                     state_r <= SETUP;
                     psel    <= 1'b1;
                     penable <= 1'b0;
                     paddr   <= cmd_addr;
                     pwrite  <= cmd_write;
                     pwdata  <= cmd_wdata;
                     pstrb   <= cmd_write ? cmd_strb : {STRB_WIDTH{1'b0}};
                     pprot   <= cmd_prot;
                  end
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            SETUP: begin
               state_r <= ACCESS;
               penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
               wait_cnt_r <= {CNT_WIDTH{1'b0}};
`endif
            end
            ACCESS: begin
               if (pready) begin
                  state_r         <= RESP;
                  psel            <= 1'b0;
                  penable         <= 1'b0;
                  rsp_valid       <= 1'b1;
                  rsp_other_error <= pslverr;
                  rsp_rdata       <= (!pwrite && !pslverr) ? prdata : {DATA_WIDTH{1'b0}};
               end else begin
`ifdef APB_TIMEOUT_EN
                  // This cycle is the last permitted wait cycle, so abort now.
                  if (wait_cnt_r == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                     state_r         <= RESP;
                     psel            <= 1'b0;
                     penable         <= 1'b0;
                     rsp_valid       <= 1'b1;
                     rsp_other_error <= 1'b1;
                     rsp_rdata       <= {DATA_WIDTH{1'b0}};
                  end else begin
                     wait_cnt_r <= wait_cnt_r + CNT_WIDTH'(1);
                  end
`else
                  state_r <= ACCESS;
`endif
               end
            end
            RESP: begin
               state_r          <= IDLE;
               cmd_ready        <= 1'b1;
               rsp_valid        <= 1'b0;
               rsp_rdata        <= {DATA_WIDTH{1'b0}};
               rsp_master_error <= 1'b0;
               rsp_other_error  <= 1'b0;
            end
            default: begin
               state_r   <= IDLE;
               cmd_ready <= 1'b1;
               rsp_valid <= 1'b0;
               psel      <= 1'b0;
               penable   <= 1'b0;
            end
         endcase
      end
   end

endmodule
